// File: rtl/mxv_pkg.sv
// Shared types and constants for the matrix-vector sequencer.
package mxv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    SAVE,
    TRANSMIT,
    FINISH
  } state_t;

  localparam logic MODE_COMPUTE = 1'b0;
  localparam logic MODE_RETX    = 1'b1;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mxv_idx_counter.sv
// Wrapping index counter: counts 0..LAST on inc, synchronous clear wins over inc.
module mxv_idx_counter #(
  parameter int unsigned W    = 1,
  parameter int unsigned LAST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  // Terminal beat: this increment returns the index to zero.
  always_comb begin
    wrap = inc && (value == W'(LAST));
  end

  // Index register with async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/mxv_sequencer.sv
// Matrix-vector multiply sequencer: per row clears the accumulator, pops COLS
// operands, saves the result, then transmits all result slots.
module mxv_sequencer
  import mxv_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         abort,
  input  logic                         fifo_empty,
  output logic                         pop,
  output logic                         acc_clr,
  output logic                         acc_wr,
  output logic [idx_width(ROWS)-1:0]   row_idx,
  output logic [idx_width(COLS)-1:0]   col_idx,
  output logic                         tx_req,
  output logic [idx_width(ROWS)-1:0]   tx_idx,
  input  logic                         tx_ack,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted
);

  localparam int unsigned RW = idx_width(ROWS);
  localparam int unsigned CW = idx_width(COLS);

  state_t state;
  state_t state_nxt;

  logic abort_take;
  logic row_inc;
  logic tx_inc;
  logic row_wrap;
  logic col_wrap;
  logic tx_wrap;

  // Abort only counts while an operation is in progress.
  always_comb begin
    abort_take = abort && (state != IDLE);
    row_inc    = (state == SAVE);
    tx_inc     = (state == TRANSMIT) && tx_ack;
  end

  mxv_idx_counter #(.W(RW), .LAST(ROWS - 1)) u_row_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (row_inc),
    .clr   (abort_take),
    .value (row_idx),
    .wrap  (row_wrap)
  );

  mxv_idx_counter #(.W(CW), .LAST(COLS - 1)) u_col_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pop),
    .clr   (abort_take),
    .value (col_idx),
    .wrap  (col_wrap)
  );

  mxv_idx_counter #(.W(RW), .LAST(ROWS - 1)) u_tx_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (tx_inc),
    .clr   (abort_take),
    .value (tx_idx),
    .wrap  (tx_wrap)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition. Mode only steers the
  // IDLE exit, so once an operation starts its path is fixed by the state.
  always_comb begin
    state_nxt = state;
    if (abort_take) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (start && !abort)
                    state_nxt = (mode == MODE_RETX) ? TRANSMIT : CLEAR;
        CLEAR:    state_nxt = MAC;
        MAC:      if (col_wrap) state_nxt = SAVE;
        SAVE:     state_nxt = row_wrap ? TRANSMIT : CLEAR;
        TRANSMIT: if (tx_wrap) state_nxt = FINISH;
        FINISH:   state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Moore output decode; pop additionally gated by FIFO availability.
  always_comb begin
    pop     = (state == MAC) && !fifo_empty;
    acc_clr = (state == CLEAR);
    acc_wr  = (state == SAVE);
    tx_req  = (state == TRANSMIT);
    busy    = (state != IDLE);
    done    = (state == FINISH);
  end

  // One-cycle cancel pulse, registered alongside the return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_take;
    end
  end

endmodule

// File: tb/tb_mxv_sequencer.sv
// Directed bench for mxv_sequencer with ROWS=3, COLS=4.
module tb_mxv_sequencer;
  import mxv_pkg::*;

  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       abort = 1'b0;
  logic       fifo_empty = 1'b0;
  logic       tx_ack = 1'b1;
  logic       pop, acc_clr, acc_wr, tx_req, busy, done, aborted;
  logic [1:0] row_idx, col_idx, tx_idx;

  int errors = 0;
  int checks = 0;

  int pop_cnt = 0, clr_cnt = 0, wr_cnt = 0, done_cnt = 0, ab_cnt = 0, excl_viol = 0;
  int wr_rows[$];
  int tx_slots[$];

  // Per-cycle trace of the current run, flags = {busy,done,aborted,tx_req,acc_wr,acc_clr,pop}
  logic [6:0] tr_f[0:199];
  logic [1:0] tr_row[0:199];
  logic [1:0] tr_col[0:199];
  logic [1:0] tr_tx[0:199];

  always #5 clk = ~clk;

  mxv_sequencer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .pop        (pop),
    .acc_clr    (acc_clr),
    .acc_wr     (acc_wr),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .tx_req     (tx_req),
    .tx_idx     (tx_idx),
    .tx_ack     (tx_ack),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  // Event counters and strobe-exclusivity watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (pop === 1'b1) pop_cnt <= pop_cnt + 1;
    if (acc_clr === 1'b1) clr_cnt <= clr_cnt + 1;
    if (acc_wr === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      wr_rows.push_back(int'(row_idx));
    end
    if (tx_req === 1'b1 && tx_ack === 1'b1) tx_slots.push_back(int'(tx_idx));
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (aborted === 1'b1) ab_cnt <= ab_cnt + 1;
    if ($countones({pop, acc_clr, acc_wr, tx_req}) > 1 ||
        ((busy === 1'b0 || done === 1'b1) && {pop, acc_clr, acc_wr, tx_req} !== 4'b0000))
      excl_viol <= excl_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One operation: start in cycle 0, k counts cycles after the start edge.
  task automatic run(input logic m, input int e_lo, input int e_hi, input int ack_dly,
                     input int abort_k, input int start_k, input int rst_k,
                     output int lat, output bit ab);
    int k;
    int hold;
    bit fin;
    lat = -1; ab = 1'b0; hold = 0; fin = 1'b0; k = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = m; abort = 1'b0; fifo_empty = 1'b0; tx_ack = (ack_dly == 0);
    while (!fin) begin
      @(negedge clk);
      tr_f[k]   = {busy, done, aborted, tx_req, acc_wr, acc_clr, pop};
      tr_row[k] = row_idx;
      tr_col[k] = col_idx;
      tr_tx[k]  = tx_idx;
      if (done === 1'b1) begin
        lat = k; fin = 1'b1;
      end else if (aborted === 1'b1) begin
        ab = 1'b1; fin = 1'b1;
      end else if (k >= 150) begin
        checks++; errors++;
        $error("FAIL run_timeout: observed no done after %0d cycles expected done", k);
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        k++;
        start      = (k == start_k);
        abort      = (k == abort_k);
        fifo_empty = (k >= e_lo && k <= e_hi);
        if (ack_dly != 0) begin
          if (tx_req === 1'b1) begin
            tx_ack = (hold == ack_dly);
            hold   = tx_ack ? 0 : hold + 1;
          end else begin
            tx_ack = 1'b0; hold = 0;
          end
        end
        if (k == rst_k) begin
          rst = 1'b0; #1;
          chk("rst_async_outputs",
              {pop, acc_clr, acc_wr, tx_req, busy, done, aborted, row_idx, col_idx, tx_idx}, 0);
          fin = 1'b1;
        end
      end
    end
    start = 1'b0; abort = 1'b0; fifo_empty = 1'b0; tx_ack = 1'b1;
  endtask

  int lat;
  bit ab;
  int p0, c0, w0, d0, a0;

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #1 chk("reset_outputs",
           {pop, acc_clr, acc_wr, tx_req, busy, done, aborted, row_idx, col_idx, tx_idx}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset_busy", busy, 0);

    // Mode 0, FIFO never empty, ack tied high
    p0 = pop_cnt; c0 = clr_cnt; w0 = wr_cnt; d0 = done_cnt;
    run(MODE_COMPUTE, -1, -1, 0, -1, -1, -1, lat, ab);
    chk("m0_latency", lat, 22);
    chk("m0_first_clear", tr_f[1][1], 1);
    chk("m0_row0_col3_pop", {tr_f[5][0], tr_col[5]}, {1'b1, 2'd3});
    chk("m0_save_row0", {tr_f[6][2], tr_row[6]}, {1'b1, 2'd0});
    chk("m0_tx_start", {tr_f[19][3], tr_tx[19]}, {1'b1, 2'd0});
    @(negedge clk);
    chk("m0_pops", pop_cnt - p0, 12);
    chk("m0_clears", clr_cnt - c0, 3);
    chk("m0_writes", wr_cnt - w0, 3);
    chk("m0_done_once", done_cnt - d0, 1);
    chk("m0_wr_log_size", wr_rows.size(), 3);
    chk("m0_tx_log_size", tx_slots.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("m0_wr_row", wr_rows[i], i);
      chk("m0_tx_slot", tx_slots[i], i);
    end
    chk("m0_idle_after", {busy, row_idx, col_idx, tx_idx}, 0);

    // FIFO empty for 5 cycles in row 1
    p0 = pop_cnt;
    run(MODE_COMPUTE, 9, 13, 0, -1, -1, -1, lat, ab);
    chk("stall_latency", lat, 27);
    chk("stall_col_hold", {tr_f[11][0], tr_col[11]}, {1'b0, 2'd1});
    chk("stall_resume", {tr_f[14][0], tr_col[14], tr_row[14]}, {1'b1, 2'd1, 2'd1});
    @(negedge clk);
    chk("stall_pops", pop_cnt - p0, 12);

    // Mode 1 retransmit, ack after 3 wait cycles per slot
    p0 = pop_cnt; w0 = wr_cnt; d0 = done_cnt;
    run(MODE_RETX, -1, -1, 3, -1, -1, -1, lat, ab);
    chk("retx_latency", lat, 13);
    chk("retx_slot0_held", {tr_f[4][3], tr_tx[4]}, {1'b1, 2'd0});
    chk("retx_slot1", {tr_f[5][3], tr_tx[5]}, {1'b1, 2'd1});
    chk("retx_slot2_end", {tr_f[12][3], tr_tx[12]}, {1'b1, 2'd2});
    @(negedge clk);
    chk("retx_no_pop_wr", (pop_cnt - p0) + (wr_cnt - w0), 0);
    chk("retx_done_once", done_cnt - d0, 1);

    // Abort in MAC at row 1 col 2, then a clean run
    d0 = done_cnt; a0 = ab_cnt;
    run(MODE_COMPUTE, -1, -1, 0, 10, -1, -1, lat, ab);
    chk("abort_seen", ab, 1);
    chk("abort_point", {tr_row[10], tr_col[10]}, {2'd1, 2'd2});
    chk("abort_idle_zeroed", {tr_f[11][6], tr_row[11], tr_col[11], tr_tx[11]}, 0);
    @(negedge clk);
    chk("abort_pulse_width", aborted, 0);
    chk("abort_count", ab_cnt - a0, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    run(MODE_COMPUTE, -1, -1, 0, -1, -1, -1, lat, ab);
    chk("rerun_start_idx", {tr_f[1][1], tr_row[1], tr_col[1]}, {1'b1, 2'd0, 2'd0});
    chk("rerun_latency", lat, 22);

    // Reset asserted while transmitting slot 1
    @(negedge clk);
    d0 = done_cnt; a0 = ab_cnt;
    run(MODE_RETX, -1, -1, 3, -1, -1, 6, lat, ab);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_no_pulses", (done_cnt - d0) + (ab_cnt - a0), 0);
    chk("rst_idle_after", {busy, tx_idx}, 0);
    run(MODE_COMPUTE, -1, -1, 0, -1, -1, -1, lat, ab);
    chk("rst_rerun_latency", lat, 22);

    // Abort in IDLE, start+abort together, start during MAC: all ignored
    @(negedge clk);
    a0 = ab_cnt; p0 = pop_cnt;
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ignored", {busy, aborted}, 0);
    @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    @(negedge clk);
    chk("start_abort_ignored", {busy, aborted}, 0);
    run(MODE_COMPUTE, -1, -1, 0, -1, 3, -1, lat, ab);
    chk("busy_start_latency", lat, 22);
    @(negedge clk);
    chk("busy_start_pops", pop_cnt - p0, 12);
    chk("never_aborted", ab_cnt - a0, 0);

    chk("strobe_exclusive", excl_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
